// File: rtl/fetch_buffer.sv
// fetch_buffer: prefetch queue between instruction memory and the fetch stage.
// Issues sequential word fetches (one outstanding at a time), stores returned
// {pc, instr} pairs in a DEPTH-entry circular FIFO and presents the head with
// registered outputs. A flush drops queued and in-flight words and restarts
// fetching at flush_addr.
// Optional feature macro: FETCH_BUFFER_MISALIGN_EN (misaligned redirect raises
// a fetch exception entry instead of fetching).
module fetch_buffer #(
    parameter int unsigned DEPTH      = 4,
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [31:0] flush_addr,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic        out_exception,
    output logic [31:0] out_etval,
    output logic        mem_valid,
    output logic        mem_instr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [31:0]   NOP     = 32'h0000_0013;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   fpc_q, fpc_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic          mem_valid_q, mem_valid_d;
    logic          halt_q, halt_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          out_valid_q, out_valid_d;
    logic [31:0]   out_pc_q, out_pc_d;
    logic [31:0]   out_instr_q, out_instr_d;
    logic          out_exc_q, out_exc_d;
    logic [31:0]   out_etval_q, out_etval_d;

    logic [31:0]   pc_mem_q    [DEPTH];
    logic [31:0]   instr_mem_q [DEPTH];
    logic          exc_mem_q   [DEPTH];

    logic          pop, push, push_exc, head_exc;
    logic [31:0]   push_pc, push_instr, head_pc, head_instr;
    logic [PW-1:0] wr_idx;
    logic [CW-1:0] count_ap;
    logic          flush_mis;
    logic [31:0]   flush_tgt;

`ifdef FETCH_BUFFER_MISALIGN_EN
    assign flush_mis = (flush_addr[1:0] != 2'b00);
    assign flush_tgt = flush_addr;
`else
    assign flush_mis = 1'b0;
    assign flush_tgt = flush_addr & 32'hFFFF_FFFC;
`endif

    // Next-state logic: fetch FSM, FIFO pointers and the next head registers.
    always_comb begin
        state_d    = state_q;
        fpc_d      = fpc_q;
        halt_d     = halt_q;
        push       = 1'b0;
        push_pc    = fpc_q;
        push_instr = mem_rdata;
        push_exc   = 1'b0;
        // A flush wins over a pop in the same cycle.
        pop        = out_valid_q & out_ready & ~flush;
        count_ap   = count_q - CW'(pop);

        if (flush) begin
            fpc_d  = flush_tgt;
            halt_d = flush_mis;
            if (flush_mis) begin
                push       = 1'b1;
                push_pc    = flush_addr;
                push_instr = NOP;
                push_exc   = 1'b1;
            end else begin
                push       = 1'b0;
            end
            // An outstanding request must still complete; its data is dropped.
            case (state_q)
                S_REQ, S_DISCARD: state_d = mem_ready ? S_IDLE : S_DISCARD;
                default:          state_d = S_IDLE;
            endcase
        end else begin
            case (state_q)
                S_IDLE: begin
                    if ((count_ap < DEPTH_C) && !halt_q) state_d = S_REQ;
                    else                                 state_d = S_IDLE;
                end
                S_REQ: begin
                    if (mem_ready) begin
                        push  = 1'b1;
                        fpc_d = fpc_q + 32'd4;
                        state_d = ((count_ap + CW'(1)) < DEPTH_C) ? S_REQ : S_IDLE;
                    end else begin
                        state_d = S_REQ;
                    end
                end
                S_DISCARD: begin
                    if (mem_ready) state_d = ((count_ap < DEPTH_C) && !halt_q) ? S_REQ : S_IDLE;
                    else           state_d = S_DISCARD;
                end
                default: state_d = S_IDLE;
            endcase
        end

        // A flush empties the FIFO; a misaligned-redirect entry then lands in slot 0.
        wr_idx   = flush ? '0 : wr_ptr_q;
        rd_ptr_d = (flush ? '0 : rd_ptr_q) + PW'(pop);
        wr_ptr_d = wr_idx + PW'(push);
        count_d  = (flush ? '0 : count_ap) + CW'(push);

        // A new request presents fpc; a pending one keeps its address.
        mem_valid_d = (state_d != S_IDLE);
        if ((state_d == S_REQ) && ((state_q != S_REQ) || mem_ready)) mem_addr_d = fpc_d;
        else                                                          mem_addr_d = mem_addr_q;

        // Head seen next cycle: bypass the word being written if it becomes the head.
        if (push && (rd_ptr_d == wr_idx)) begin
            head_pc    = push_pc;
            head_instr = push_instr;
            head_exc   = push_exc;
        end else begin
            head_pc    = pc_mem_q[rd_ptr_d];
            head_instr = instr_mem_q[rd_ptr_d];
            head_exc   = exc_mem_q[rd_ptr_d];
        end
        out_valid_d = (count_d != '0);
        out_pc_d    = out_valid_d ? head_pc : 32'h0000_0000;
        out_instr_d = out_valid_d ? head_instr : NOP;
        out_exc_d   = out_valid_d & head_exc;
        out_etval_d = out_exc_d ? head_pc : 32'h0000_0000;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            fpc_q       <= RESET_ADDR;
            mem_addr_q  <= 32'h0000_0000;
            mem_valid_q <= 1'b0;
            halt_q      <= 1'b0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_pc_q    <= 32'h0000_0000;
            out_instr_q <= NOP;
            out_exc_q   <= 1'b0;
            out_etval_q <= 32'h0000_0000;
        end else begin
            state_q     <= state_d;
            fpc_q       <= fpc_d;
            mem_addr_q  <= mem_addr_d;
            mem_valid_q <= mem_valid_d;
            halt_q      <= halt_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_pc_q    <= out_pc_d;
            out_instr_q <= out_instr_d;
            out_exc_q   <= out_exc_d;
            out_etval_q <= out_etval_d;
        end
    end

    // FIFO storage write port; contents need no reset since count gates them.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wr_idx]    <= push_pc;
            instr_mem_q[wr_idx] <= push_instr;
            exc_mem_q[wr_idx]   <= push_exc;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_pc        = out_pc_q;
    assign out_instr     = out_instr_q;
    assign out_exception = out_exc_q;
    assign out_etval     = out_etval_q;
    assign mem_valid     = mem_valid_q;
    assign mem_addr      = mem_addr_q;
    assign mem_instr     = 1'b1;
    assign mem_wdata     = 32'h0000_0000;
    assign mem_wstrb     = 4'b0000;
endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: a queue-based reference model of the
// prefetch FIFO plus directed literal checks and a randomized phase.
`timescale 1ns/1ps
module tb_fetch_buffer;
    localparam int          DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0, rst = 1'b1, flush = 1'b0, out_ready = 1'b0, mem_ready = 1'b0;
    logic [31:0] flush_addr = 32'h0, mem_rdata = 32'h0;
    logic        out_valid, out_exception, mem_valid, mem_instr;
    logic [31:0] out_pc, out_instr, out_etval, mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;

    fetch_buffer #(.DEPTH(DEPTH), .RESET_ADDR(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .flush(flush), .flush_addr(flush_addr),
        .out_ready(out_ready), .out_valid(out_valid), .out_pc(out_pc),
        .out_instr(out_instr), .out_exception(out_exception), .out_etval(out_etval),
        .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; logic [31:0] instr; logic exc; } ent_t;
    ent_t mq[$];

    int          checks = 0, failures = 0;
    logic [31:0] exp_fpc = 32'h0;
    bit          stale = 0, halted = 0, model_on = 0, rst_req = 1;
    bit          prev_pend = 0;
    logic [31:0] prev_addr = 32'h0;
    int          wait_cnt = 0, cur_lat = 0, fixed_lat = 0, acc_cnt = 0;
    bit          lat_rand = 0;
    logic        o_valid, o_mv, o_exc;
    logic [31:0] o_pc, o_instr, o_ma, o_etval;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Sample DUT outputs at the falling edge and compare them with the model.
    task automatic obs_step();
        @(negedge clk);
        o_valid = out_valid; o_pc = out_pc; o_instr = out_instr; o_exc = out_exception;
        o_etval = out_etval; o_mv = mem_valid; o_ma = mem_addr;
        if (model_on) begin
            chk("out_valid", {31'b0, o_valid}, (mq.size() != 0) ? 32'd1 : 32'd0);
            if (mq.size() != 0) begin
                chk("out_pc", o_pc, mq[0].pc);
                chk("out_instr", o_instr, mq[0].instr);
                chk("out_exception", {31'b0, o_exc}, {31'b0, mq[0].exc});
                chk("out_etval", o_etval, mq[0].exc ? mq[0].pc : 32'h0);
            end else begin
                chk("out_instr_empty", o_instr, NOP);
                chk("out_exception_empty", {31'b0, o_exc}, 32'd0);
            end
            if (o_mv) chk("mem_addr_align", {30'b0, o_ma[1:0]}, 32'd0);
            if (prev_pend) begin
                chk("mem_valid_hold", {31'b0, o_mv}, 32'd1);
                chk("mem_addr_hold", o_ma, prev_addr);
            end else if (o_mv && !stale) begin
                chk("req_when_not_full", (mq.size() < DEPTH) ? 32'd1 : 32'd0, 32'd1);
            end
            if (halted && !stale) chk("halted_no_req", {31'b0, o_mv}, 32'd0);
        end
    endtask

    // Drive inputs for the coming edge, act as memory, and advance the model.
    task automatic drive_step(input logic fl, input logic [31:0] fa, input logic rdy);
        if (o_mv && !rst_req && (wait_cnt >= cur_lat)) begin
            mem_ready = 1'b1;
            mem_rdata = ~o_ma;
        end else begin
            mem_ready = 1'b0;
            mem_rdata = $urandom();
            if (o_mv) wait_cnt++;
        end
        flush = fl; flush_addr = fa; out_ready = rdy; rst = rst_req;
        if (rst_req) begin
            mq.delete(); exp_fpc = 32'h0; stale = 0; halted = 0;
            wait_cnt = 0; cur_lat = lat_rand ? $urandom_range(0, 3) : fixed_lat;
        end else if (fl) begin
            mq.delete();
            stale = o_mv && !mem_ready;
`ifdef FETCH_BUFFER_MISALIGN_EN
            if (fa[1:0] != 2'b00) begin
                mq.push_back('{pc: fa, instr: NOP, exc: 1'b1});
                halted = 1;
            end else begin
                halted = 0;
            end
            exp_fpc = fa;
`else
            halted  = 0;
            exp_fpc = fa & 32'hFFFF_FFFC;
`endif
        end else begin
            if ((mq.size() != 0) && rdy) void'(mq.pop_front());
            if (o_mv && mem_ready) begin
                acc_cnt++;
                if (stale) begin
                    stale = 0;
                end else begin
                    chk("fetch_addr", o_ma, exp_fpc);
                    chk("no_overflow", (mq.size() < DEPTH) ? 32'd1 : 32'd0, 32'd1);
                    mq.push_back('{pc: o_ma, instr: mem_rdata, exc: 1'b0});
                    exp_fpc = exp_fpc + 32'd4;
                end
            end
        end
        prev_pend = !rst_req && o_mv && !mem_ready;
        prev_addr = o_ma;
        if (mem_ready) begin
            wait_cnt = 0;
            cur_lat  = lat_rand ? $urandom_range(0, 3) : fixed_lat;
        end
        @(posedge clk);
        model_on = 1;
    endtask

    task automatic do_reset();
        rst_req = 1;
        repeat (3) begin obs_step(); drive_step(1'b0, 32'h0, 1'b0); end
        rst_req = 0;
    endtask

    logic        v_seq [5];
    logic [31:0] pc_seq [5];
    int          n;
    bit          found;
    logic [31:0] first_addr, new_addr, first_pc;

    initial begin
        // Reset state and first-fetch latency, zero-wait memory.
        fixed_lat = 0; lat_rand = 0;
        do_reset();
        obs_step();
        chk("rst_out_valid", {31'b0, o_valid}, 32'd0);
        chk("rst_out_instr", o_instr, NOP);
        chk("rst_out_pc", o_pc, 32'h0);
        chk("rst_out_exception", {31'b0, o_exc}, 32'd0);
        chk("rst_out_etval", o_etval, 32'h0);
        chk("rst_mem_valid", {31'b0, o_mv}, 32'd0);
        chk("mem_instr", {31'b0, mem_instr}, 32'd1);
        chk("mem_wdata", mem_wdata, 32'h0);
        chk("mem_wstrb", {28'b0, mem_wstrb}, 32'd0);
        drive_step(1'b0, 32'h0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            obs_step(); v_seq[k] = o_valid; pc_seq[k] = o_pc;
            drive_step(1'b0, 32'h0, 1'b1);
        end
        chk("lat_valid0", {31'b0, v_seq[0]}, 32'd0);
        for (int k = 1; k < 5; k++) begin
            chk("stream_valid", {31'b0, v_seq[k]}, 32'd1);
            chk("stream_pc", pc_seq[k], 32'(4 * (k - 1)));
        end

        // Stall: exactly DEPTH words accepted, then drain in order.
        do_reset();
        acc_cnt = 0;
        repeat (12) begin obs_step(); drive_step(1'b0, 32'h0, 1'b0); end
        chk("stall_accepted", 32'(acc_cnt), 32'd4);
        chk("stall_mem_valid", {31'b0, o_mv}, 32'd0);
        n = 0;
        for (int k = 0; k < 20 && n < 5; k++) begin
            obs_step();
            if (o_valid) begin pc_seq[n] = o_pc; n++; end
            drive_step(1'b0, 32'h0, 1'b1);
        end
        chk("drain_count", 32'(n), 32'd5);
        for (int k = 0; k < n; k++) chk("drain_pc", pc_seq[k], 32'(4 * k));

        // 3-cycle memory, flush during the outstanding fetch of 0x8.
        fixed_lat = 3;
        do_reset();
        found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            obs_step();
            if (o_mv && (o_ma == 32'h8) && (wait_cnt == 1)) begin
                found = 1;
                drive_step(1'b1, 32'h100, 1'b1);
            end else begin
                drive_step(1'b0, 32'h0, 1'b1);
            end
        end
        chk("flush_point_found", {31'b0, found}, 32'd1);
        first_addr = 32'hFFFF_FFFF; new_addr = 32'hFFFF_FFFF; first_pc = 32'hFFFF_FFFF;
        for (int k = 0; k < 40 && first_pc == 32'hFFFF_FFFF; k++) begin
            obs_step();
            if (o_mv && first_addr == 32'hFFFF_FFFF) first_addr = o_ma;
            if (o_mv && o_ma != 32'h8 && new_addr == 32'hFFFF_FFFF) new_addr = o_ma;
            if (o_valid) first_pc = o_pc;
            drive_step(1'b0, 32'h0, 1'b1);
        end
        chk("discard_addr_held", first_addr, 32'h8);
        chk("redirect_addr", new_addr, 32'h100);
        chk("redirect_first_pc", first_pc, 32'h100);

        // Flush together with mem_ready and out_ready.
        fixed_lat = 0;
        do_reset();
        repeat (4) begin obs_step(); drive_step(1'b0, 32'h0, 1'b1); end
        obs_step();
        chk("pre_flush_busy", {30'b0, o_mv, o_valid}, 32'd3);
        drive_step(1'b1, 32'h200, 1'b1);
        obs_step();
        chk("flush_out_valid", {31'b0, o_valid}, 32'd0);
        chk("flush_mem_idle", {31'b0, o_mv}, 32'd0);
        drive_step(1'b0, 32'h0, 1'b1);
        obs_step();
        chk("flush_req_valid", {31'b0, o_mv}, 32'd1);
        chk("flush_req_addr", o_ma, 32'h200);
        drive_step(1'b0, 32'h0, 1'b1);
        obs_step();
        chk("flush_first_pc", o_pc, 32'h200);
        drive_step(1'b0, 32'h0, 1'b1);

        // Misaligned redirect.
        repeat (2) begin obs_step(); drive_step(1'b0, 32'h0, 1'b1); end
        obs_step();
        drive_step(1'b1, 32'h102, 1'b0);
`ifdef FETCH_BUFFER_MISALIGN_EN
        obs_step();
        chk("mis_valid", {31'b0, o_valid}, 32'd1);
        chk("mis_exception", {31'b0, o_exc}, 32'd1);
        chk("mis_etval", o_etval, 32'h102);
        chk("mis_pc", o_pc, 32'h102);
        chk("mis_instr", o_instr, NOP);
        drive_step(1'b0, 32'h0, 1'b0);
        repeat (6) begin
            obs_step();
            chk("mis_no_fetch", {31'b0, o_mv}, 32'd0);
            drive_step(1'b0, 32'h0, 1'b1);
        end
`else
        new_addr = 32'hFFFF_FFFF;
        for (int k = 0; k < 6 && new_addr == 32'hFFFF_FFFF; k++) begin
            obs_step();
            if (o_mv) new_addr = o_ma;
            drive_step(1'b0, 32'h0, 1'b0);
        end
        chk("mis_forced_align", new_addr, 32'h100);
`endif

        // Randomized traffic: random latency, back-pressure and redirects.
        lat_rand = 1;
        do_reset();
        repeat (3000) begin
            logic        fl;
            logic [31:0] fa;
            obs_step();
            fl = ($urandom_range(0, 99) < 3);
            fa = $urandom() & 32'h0000_FFFC;
            if ($urandom_range(0, 7) == 0) fa = 32'hFFFF_FFF0;
`ifdef FETCH_BUFFER_MISALIGN_EN
            if ($urandom_range(0, 3) == 0) fa = fa | 32'(($urandom_range(1, 3)));
`else
            fa = fa | 32'(($urandom_range(0, 3)));
`endif
            drive_step(fl, fa, ($urandom_range(0, 99) < 65));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
